// File: rtl/mema_ctrl.sv
// A-matrix memory controller: loads one DIM x DIM tile row by row into the
// A-memory FIFOs, then streams it to the array for 2*DIM-1 non-stalled cycles.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | accepting rows 0..DIM-1 into the A-memory
// READY  | full tile held, waiting for go
// STREAM | shifting the FIFOs toward the array, paused by stall
module mema_ctrl #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                row_valid,
  input  logic signed [DIM-1:0][BITS_AB-1:0]  row_data,
  output logic                                row_ready,
  input  logic                                go,
  input  logic                                stall,
  input  logic                                abort,
  output logic                                mem_en,
  output logic                                mem_wren,
  output logic [$clog2(DIM)-1:0]              mem_arow,
  output logic signed [DIM-1:0][BITS_AB-1:0]  mem_ain,
  output logic                                loaded,
  output logic                                busy,
  output logic                                a_valid,
  output logic                                done
);

  localparam int ROW_W = $clog2(DIM);
  localparam int STR_W = $clog2(2 * DIM);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(DIM - 1);
  localparam logic [STR_W-1:0] STR_LAST = STR_W'(2 * DIM - 2);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_READY  = 2'd2,
    S_STREAM = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   row_cnt_q, row_cnt_d;
  logic [STR_W-1:0]   str_cnt_q, str_cnt_d;
  logic               done_q, done_d;
  logic               accept;

  assign accept = (state_q == S_LOAD) && row_valid && !abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      row_cnt_q <= '0;
      str_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      str_cnt_q <= str_cnt_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    str_cnt_d = str_cnt_q;
    done_d    = 1'b0;
    if (abort) begin
      state_d   = S_IDLE;
      row_cnt_d = '0;
      str_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d   = S_LOAD;
            row_cnt_d = '0;
          end
        end
        S_LOAD: begin
          if (row_valid) begin
            if (row_cnt_q == ROW_LAST) begin
              state_d   = S_READY;
              row_cnt_d = '0;
            end else begin
              row_cnt_d = row_cnt_q + ROW_W'(1);
            end
          end
        end
        S_READY: begin
          if (go) begin
            state_d   = S_STREAM;
            str_cnt_d = '0;
          end
        end
        S_STREAM: begin
          // 2*DIM-1 shifts drain the deepest FIFO skew of DIM-1
          if (!stall) begin
            if (str_cnt_q == STR_LAST) begin
              state_d   = S_IDLE;
              str_cnt_d = '0;
              done_d    = 1'b1;
            end else begin
              str_cnt_d = str_cnt_q + STR_W'(1);
            end
          end
        end
        default: begin
          state_d   = S_IDLE;
          row_cnt_d = '0;
          str_cnt_d = '0;
        end
      endcase
    end
  end

  // Outputs are forced low while rst is held, even before the edge lands
  always_comb begin
    row_ready = 1'b0;
    mem_en    = 1'b0;
    mem_wren  = 1'b0;
    mem_arow  = '0;
    mem_ain   = '0;
    loaded    = 1'b0;
    busy      = 1'b0;
    a_valid   = 1'b0;
    done      = 1'b0;
    if (!rst) begin
      row_ready = (state_q == S_LOAD);
      loaded    = (state_q == S_READY);
      busy      = (state_q == S_LOAD) || (state_q == S_STREAM);
      done      = done_q;
      if (accept) begin
        mem_en   = 1'b1;
        mem_wren = 1'b1;
        mem_arow = row_cnt_q;
        mem_ain  = row_data;
      end
      if (state_q == S_STREAM) begin
        a_valid = !stall;
        mem_en  = !stall && !abort;
      end
    end
  end

endmodule

// File: tb/tb_mema_ctrl.sv
// Scoreboard bench for mema_ctrl: scenario tasks push the expected per-cycle
// memory-side activity, a negedge monitor pops and compares it.
module tb_mema_ctrl;
  localparam int DIM = 8;
  localparam int B   = 8;
  localparam int RW  = $clog2(DIM);
  localparam int SLEN = 2 * DIM - 1;

  logic clk = 1'b0;
  logic rst, start, row_valid, go, stall, abort;
  logic signed [DIM-1:0][B-1:0] row_data;
  logic row_ready, mem_en, mem_wren, loaded, busy, a_valid, done;
  logic [RW-1:0] mem_arow;
  logic signed [DIM-1:0][B-1:0] mem_ain;

  mema_ctrl #(.BITS_AB(B), .DIM(DIM)) dut (
    .clk(clk), .rst(rst), .start(start), .row_valid(row_valid),
    .row_data(row_data), .row_ready(row_ready), .go(go), .stall(stall),
    .abort(abort), .mem_en(mem_en), .mem_wren(mem_wren), .mem_arow(mem_arow),
    .mem_ain(mem_ain), .loaded(loaded), .busy(busy), .a_valid(a_valid),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               cyc;
    logic             en, wren, av, dn;
    logic [RW-1:0]    arow;
    logic [DIM*B-1:0] ain;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   done_cyc = -1;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    e = '{default: 0};
    e.cyc = cyc;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      n_chk++; n_fail++;
      $display("FAIL stale_expect: entry for cyc %0d never matched (now %0d)", q[0].cyc, cyc);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].cyc == cyc) e = q.pop_front();
    n_chk++;
    if (mem_en !== e.en || mem_wren !== e.wren || a_valid !== e.av || done !== e.dn ||
        mem_arow !== e.arow || mem_ain !== e.ain) begin
      n_fail++;
      $display("FAIL mem_side cyc %0d: got en=%b wren=%b av=%b done=%b arow=%0d ain=%h, want en=%b wren=%b av=%b done=%b arow=%0d ain=%h",
               cyc, mem_en, mem_wren, a_valid, done, mem_arow, mem_ain,
               e.en, e.wren, e.av, e.dn, e.arow, e.ain);
    end
    if (done === 1'b1) begin
      done_cyc = cyc;
      done_cnt++;
    end
  end

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic push(logic en, logic wren, logic av, logic dn, int row, logic [DIM*B-1:0] d);
    exp_t e;
    e.cyc = cyc; e.en = en; e.wren = wren; e.av = av; e.dn = dn;
    e.arow = RW'(row); e.ain = d;
    q.push_back(e);
  endtask

  // Advance to the next cycle and drive quiet inputs with fresh random data
  task automatic nxt();
    @(posedge clk);
    #1;
    start = 0; row_valid = 0; go = 0; stall = 0; abort = 0;
    row_data = {$urandom, $urandom};
  endtask

  // mode 0: back-to-back rows, 1: alternating 1,0,1,0, 2: random gaps
  task automatic do_load(int mode, bit skip_start, int abort_after);
    int acc = 0;
    int t = 0;
    if (!skip_start) begin
      nxt(); start = 1;
    end
    while (acc < DIM) begin
      nxt();
      if (abort_after >= 0 && acc == abort_after) begin
        abort = 1; row_valid = 1;
        nxt();
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_ready", row_ready, 0);
        return;
      end
      row_valid = (mode == 0) ? 1'b1 : (mode == 1) ? ((t % 2) == 0) : 1'($urandom_range(0, 1));
      go = 1'($urandom_range(0, 1));
      stall = 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1));
      if (row_valid) begin
        push(1, 1, 0, 0, acc, row_data);
        acc++;
      end
      #1;
      chk("load_row_ready", row_ready, 1);
      chk("load_busy", busy, 1);
      t++;
    end
    nxt();
    #1;
    chk("ready_loaded", loaded, 1);
    chk("ready_busy", busy, 0);
  endtask

  // Called in the READY cycle. smode 0: no stall, 1: 3 stalls mid-stream, 2: random.
  task automatic do_stream(int smode, bit noise, int rst_at, bit start_w_done);
    int k = 0;
    int s = 0;
    int nst = 0;
    int go_cyc;
    go = 1;
    go_cyc = cyc;
    while (k < SLEN) begin
      nxt();
      s++;
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        go = 1'($urandom_range(0, 1));
        row_valid = 1'($urandom_range(0, 1));
      end
      if (s == rst_at) begin
        rst = 1;
        nxt();
        rst = 0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_loaded", loaded, 0);
        return;
      end
      if ((smode == 1 && k == 7 && nst < 3) ||
          (smode == 2 && nst < 10 && $urandom_range(0, 3) == 0)) begin
        stall = 1;
        nst++;
      end else begin
        push(1, 0, 1, 0, 0, '0);
        k++;
      end
      #1;
      chk("stream_busy", busy, 1);
    end
    nxt();
    push(0, 0, 0, 1, 0, '0);
    if (start_w_done) start = 1;
    #1;
    chk("done_busy", busy, 0);
    @(negedge clk);
    #1;
    chk("done_latency", done_cyc - go_cyc, SLEN + 1 + nst);
  endtask

  initial begin
    int dc;
    rst = 1; start = 0; row_valid = 0; go = 0; stall = 0; abort = 0; row_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_loaded", loaded, 0);
    chk("reset_row_ready", row_ready, 0);
    nxt();
    rst = 0;
    repeat (2) nxt();

    // basic back-to-back load, unstalled stream
    do_load(0, 0, -1);
    do_stream(0, 0, 0, 0);
    // alternating row_valid, 3-cycle stall
    nxt();
    do_load(1, 0, -1);
    do_stream(1, 0, 0, 0);
    // abort after 4 rows, then reload from row 0; start/go noise while streaming
    nxt();
    do_load(0, 0, 4);
    do_load(0, 0, -1);
    dc = done_cnt;
    do_stream(0, 1, 0, 0);
    chk("single_done", done_cnt - dc, 1);
    // reset at stream cycle 5, then a clean full sequence
    nxt();
    do_load(0, 0, -1);
    do_stream(0, 0, 5, 0);
    do_load(0, 0, -1);
    do_stream(0, 0, 0, 1);
    // start honoured in the done cycle, followed by random runs
    do_load(2, 1, -1);
    do_stream(2, 1, 0, 0);
    for (int r = 0; r < 4; r++) begin
      nxt();
      do_load(2, 0, -1);
      do_stream(2, 1, 0, 0);
    end
    repeat (4) nxt();
    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mema_ctrl.md
MEMA_CTRL -- requirements
Module: mema_ctrl

Interface
REQ-001 SHALL have parameter BITS_AB, default 8: element width of one A-matrix entry.
REQ-002 SHALL have parameter DIM, default 8: array dimension; a power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit: single-cycle request to begin loading a new A tile.
REQ-006 SHALL have port row_valid, input, 1 bit: row_data carries a valid row.
REQ-007 SHALL have port row_data, input, DIM x BITS_AB signed: one A row.
REQ-008 SHALL have port row_ready, output, 1 bit: controller accepts the row this cycle.
REQ-009 SHALL have port go, input, 1 bit: single-cycle request to stream the loaded tile.
REQ-010 SHALL have port stall, input, 1 bit: downstream hold while streaming.
REQ-011 SHALL have port abort, input, 1 bit: cancel the current operation.
REQ-012 SHALL have port mem_en, output, 1 bit: shift/write enable to the A-memory FIFOs.
REQ-013 SHALL have port mem_wren, output, 1 bit: write enable to the A-memory.
REQ-014 SHALL have port mem_arow, output, clog2(DIM) bits: target row index.
REQ-015 SHALL have port mem_ain, output, DIM x BITS_AB signed: row data to the A-memory.
REQ-016 SHALL have port loaded, output, 1 bit: a full tile is held and waiting for go.
REQ-017 SHALL have port busy, output, 1 bit: asserted in LOAD or STREAM.
REQ-018 SHALL have port a_valid, output, 1 bit: A-memory outputs are meaningful to the array this cycle.
REQ-019 SHALL have port done, output, 1 bit: single-cycle pulse at the end of streaming.

Function
REQ-020 SHALL implement FSM states IDLE, LOAD, READY and STREAM.
REQ-021 IDLE: start=1 SHALL move the FSM to LOAD and clear row_cnt to 0; all other inputs are ignored.
REQ-022 LOAD: row_ready SHALL be 1.
REQ-023 LOAD: each cycle with row_valid=1 (accept) SHALL drive, combinationally in that cycle, mem_en=1, mem_wren=1, mem_arow=row_cnt, mem_ain=row_data, and increment row_cnt.
REQ-024 LOAD: a cycle without accept SHALL drive mem_en=0 and mem_wren=0.
REQ-025 LOAD: the accept with row_cnt=DIM-1 SHALL move the FSM to READY and wrap row_cnt to 0.
REQ-026 READY: loaded SHALL be 1, and go=1 SHALL move the FSM to STREAM with str_cnt=0.
REQ-027 STREAM: mem_wren SHALL be 0, mem_en SHALL equal !stall, and str_cnt SHALL increment only when stall=0.
REQ-028 STREAM: a_valid SHALL equal !stall.
REQ-029 STREAM: the non-stalled cycle with str_cnt=2*DIM-2 SHALL be the last; the following cycle SHALL assert done=1 in IDLE. Non-stalled STREAM length is exactly 2*DIM-1 cycles, which covers the maximum FIFO skew of DIM-1.
REQ-030 str_cnt SHALL be clog2(2*DIM) bits wide and SHALL never wrap within one stream.
REQ-031 Outside accept and non-stalled STREAM cycles, mem_en, mem_wren and a_valid SHALL be 0.
REQ-032 Outside accept cycles, mem_arow and mem_ain SHALL be 0.
REQ-033 busy SHALL be 1 exactly in LOAD and STREAM.
REQ-034 start SHALL be ignored outside IDLE.
REQ-035 go SHALL be ignored outside READY.
REQ-036 row_valid SHALL be ignored outside LOAD.
REQ-037 stall SHALL be ignored outside STREAM.
REQ-038 abort=1 in any state SHALL return the FSM to IDLE next cycle and clear both counters, with no done pulse.
REQ-039 abort SHALL take priority over start, go, accept and the stream-end transition in the same cycle.
REQ-040 mem_en and mem_wren SHALL be 0 in the abort cycle.
REQ-041 A start in the same cycle as done (already in IDLE) SHALL be honoured.

Reset
REQ-042 rst=1 SHALL set the FSM to IDLE, row_cnt=0 and str_cnt=0 on the next edge.
REQ-043 rst SHALL have priority over all inputs, including abort.
REQ-044 During and after reset until the next start, all outputs SHALL be 0, including mem_arow and mem_ain.
REQ-045 Reset mid-LOAD or mid-STREAM SHALL discard progress with no done pulse.

Verification
REQ-046 Bench SHALL cover (DIM=8): start, 8 back-to-back rows with row_valid=1, then go with stall=0 -> mem_arow 0..7 on the 8 accept cycles, loaded=1, then mem_en=1 and a_valid=1 for exactly 15 cycles, then done=1 for 1 cycle.
REQ-047 Bench SHALL cover: row_valid toggling 1,0,1,0... during LOAD -> 8 accepts only, with mem_wren=0 on gap cycles and rows landing in order 0..7.
REQ-048 Bench SHALL cover: stall=1 for 3 cycles mid-STREAM -> mem_en=0 and a_valid=0 for those 3 cycles, and done arrives exactly 3 cycles later than in the REQ-046 run.
REQ-049 Bench SHALL cover: abort after 4 accepted rows -> IDLE next cycle, no done; a subsequent start reloads beginning at mem_arow=0.
REQ-050 Bench SHALL cover: start and go pulsed during STREAM -> no effect, same 15-cycle stream and single done.
REQ-051 Bench SHALL cover: rst=1 at stream cycle 5 -> all outputs 0 next cycle, no done; a subsequent full sequence runs as in REQ-046.
